vend_fsm: RTL

Vending-machine control FSM that consumes the single-cycle key pulses produced by the key debounce stage (`key_out[3:0]`, active-high, one clock wide per press). It accumulates coin credit, decides purchase or refund, and drives hold-timed dispense and change outputs for the LED/display layer. It sits directly downstream of the debouncer in the top-level vending design.

---
 rtl/vend_pkg.sv | 45 ++++
 rtl/vend_if.sv | 23 ++
 rtl/vend_fsm_hold_timer.sv | 27 ++
 rtl/vend_fsm.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding, key bit
// positions, coin values and the credit width, plus key-to-event decode.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAY      = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_e;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_COIN   = 2'd1,
    EV_BUY    = 2'd2,
    EV_CANCEL = 2'd3
  } vend_event_e;

  localparam int KEY_C05    = 0;
  localparam int KEY_C1     = 1;
  localparam int KEY_BUY    = 2;
  localparam int KEY_CANCEL = 3;

  localparam int CREDIT_W = 4;

  // Coin values carry one extra bit so the credit sum never wraps.
  localparam logic [CREDIT_W:0] COIN05_VAL = 5'd1;
  localparam logic [CREDIT_W:0] COIN1_VAL  = 5'd2;

  // Single winning event per cycle: cancel > buy > coin.
  function automatic vend_event_e key_event(logic [3:0] key);
    if (key[KEY_CANCEL]) return EV_CANCEL;
    if (key[KEY_BUY]) return EV_BUY;
    if (key[KEY_C1] || key[KEY_C05]) return EV_COIN;
    return EV_NONE;
  endfunction

  // Coin 1 yuan outranks coin 0.5 yuan when both pulse together.
  function automatic logic [CREDIT_W:0] coin_value(logic [3:0] key);
    if (key[KEY_C1]) return COIN1_VAL;
    if (key[KEY_C05]) return COIN05_VAL;
    return '0;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Key pulses in, credit/dispense/change indications out.
// master: the debouncer/bench side; slave: the vending FSM.
interface vend_if;
  import vend_pkg::*;

  logic [3:0]          key_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                short_pulse;

  modport master (
    output key_pulse,
    input  credit, dispense, change_valid, change_amt, coin_reject, short_pulse
  );

  modport slave (
    input  key_pulse,
    output credit, dispense, change_valid, change_amt, coin_reject, short_pulse
  );
endinterface

// File: rtl/vend_fsm_hold_timer.sv
// Loadable down-counter that times the dispense and change hold phases.
// done is high whenever the count reads zero.
module hold_timer #(
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int TW = $clog2(HOLD_CYC);
  localparam logic [TW-1:0] LOAD_V = TW'(HOLD_CYC - 1);

  logic [TW-1:0] cnt;

  // Load on phase entry, then count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_V;
    else if (cnt != '0)
      cnt <= cnt - TW'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/vend_fsm.sv
// Vending controller: accumulates coin credit, handles buy/cancel and
// drives hold-timed dispense and change indications.
// Optional feature macro: VEND_AUTO_BUY_EN (purchase as soon as credit
// reaches the price, without pressing buy).
//
//   state    | meaning
//   IDLE     | no credit
//   PAY      | credit > 0, waiting for coins/buy/cancel
//   DISPENSE | dispense held for HOLD_CYC cycles
//   CHANGE   | change_amt presented for HOLD_CYC cycles
module vend_fsm
  import vend_pkg::*;
#(
  parameter int PRICE      = 5,
  parameter int CREDIT_MAX = 15,
  parameter int HOLD_CYC   = 50_000_000
) (
  input logic clk,
  input logic rst_n,
  vend_if.slave bus
);
  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CREDIT_W:0]   MAX_V   = CW1'(CREDIT_MAX);
  localparam logic [CREDIT_W:0]   PRICE_V = CW1'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
`ifdef VEND_AUTO_BUY_EN
  localparam bit AUTO_BUY = 1'b1;
`else
  localparam bit AUTO_BUY = 1'b0;
`endif

  vend_state_e         state;
  logic [CREDIT_W-1:0] credit_q, change_q, camt_q;
  logic                disp_q, cv_q, rej_q, short_q;

  vend_event_e         ev;
  logic [CREDIT_W:0]   coin_val, sum;
  logic                coin_ok, can_buy, auto_hit, timer_load, done;

  // Event decode, saturating-sum check and hold-timer load on phase entry.
  always_comb begin
    ev         = key_event(bus.key_pulse);
    coin_val   = coin_value(bus.key_pulse);
    sum        = {1'b0, credit_q} + coin_val;
    coin_ok    = (sum <= MAX_V);
    can_buy    = ({1'b0, credit_q} >= PRICE_V);
    auto_hit   = AUTO_BUY && (sum >= PRICE_V);
    timer_load = 1'b0;
    case (state)
      ST_IDLE, ST_PAY: begin
        if (ev == EV_COIN)
          timer_load = coin_ok && auto_hit;
        else if (state == ST_PAY)
          timer_load = (ev == EV_CANCEL) || ((ev == EV_BUY) && can_buy);
      end
      ST_DISPENSE: timer_load = done && (change_q != '0);
      default:     timer_load = 1'b0;
    endcase
  end

  hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .done (done)
  );

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      camt_q   <= '0;
      disp_q   <= 1'b0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      rej_q   <= 1'b0;
      short_q <= 1'b0;
      case (state)
        ST_IDLE, ST_PAY: begin
          case (ev)
            EV_CANCEL: if (state == ST_PAY) begin
              change_q <= credit_q;
              camt_q   <= credit_q;
              credit_q <= '0;
              cv_q     <= 1'b1;
              state    <= ST_CHANGE;
            end
            EV_BUY: if (state == ST_PAY) begin
              if (can_buy) begin
                change_q <= credit_q - PRICE_C;
                credit_q <= '0;
                disp_q   <= 1'b1;
                state    <= ST_DISPENSE;
              end else begin
                short_q <= 1'b1;
              end
            end
            EV_COIN: begin
              if (!coin_ok) begin
                rej_q <= 1'b1;
              end else if (auto_hit) begin
                change_q <= sum[CREDIT_W-1:0] - PRICE_C;
                credit_q <= '0;
                disp_q   <= 1'b1;
                state    <= ST_DISPENSE;
              end else begin
                credit_q <= sum[CREDIT_W-1:0];
                state    <= ST_PAY;
              end
            end
            default: ;
          endcase
        end
        ST_DISPENSE: begin
          rej_q <= (ev == EV_COIN);
          if (done) begin
            disp_q <= 1'b0;
            if (change_q != '0) begin
              camt_q <= change_q;
              cv_q   <= 1'b1;
              state  <= ST_CHANGE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          rej_q <= (ev == EV_COIN);
          if (done) begin
            cv_q     <= 1'b0;
            camt_q   <= '0;
            change_q <= '0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = disp_q;
  assign bus.change_valid = cv_q;
  assign bus.change_amt   = camt_q;
  assign bus.coin_reject  = rej_q;
  assign bus.short_pulse  = short_q;
endmodule
